// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs symbolic LEGv8 LDUR/STUR/CBZ/B requests into machine words
// and streams them into instruction memory at sequential addresses.
module instr_encoder_loader #(
    parameter int DEPTH     = 64,
    parameter int ADDR_STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] base_addr,
    input  logic        finish,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rn,
    input  logic [63:0] in_imm,
    output logic        mem_we,
    input  logic        mem_ready,
    output logic [63:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [6:0]  count,
    output logic        busy,
    output logic        done,
    output logic        err_range
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam logic [7:0] DEPTH_W = 8'(DEPTH);
    state_t state, state_nxt;
    logic [7:0] occupied;
    logic [31:0] enc;
    logic restart, accept, drain_out, in_range, ok9, ok19, ok26;
    // a pending write already owns a slot, so it counts against DEPTH
    assign occupied  = {1'b0, count} + {7'b0, mem_we};
    assign drain_out = mem_we && mem_ready;
    assign restart   = start && (state == IDLE || state == DONE);
    assign in_ready  = (state == RUN) && (!mem_we || mem_ready) && (occupied < DEPTH_W);
    assign accept    = in_valid && in_ready;
    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = state == DONE;
    assign ok9       = in_imm[63:8]  == {56{in_imm[8]}};
    assign ok19      = in_imm[63:18] == {46{in_imm[18]}};
    assign ok26      = in_imm[63:25] == {39{in_imm[25]}};
    assign in_range  = in_op[1] ? (in_op[0] ? ok26 : ok19) : ok9;
    assign enc = in_op == 2'b11 ? {6'b000101, in_imm[25:0]} :
                 in_op == 2'b10 ? {8'hB4, in_imm[18:0], in_rt} :
                 {in_op[0] ? 11'h7C0 : 11'h7C2, in_imm[8:0], 2'b00, in_rn, in_rt};
    always_comb begin
        state_nxt = restart ? RUN :
                    (state == RUN && (finish || occupied >= DEPTH_W)) ? DRAIN :
                    (state == DRAIN && !mem_we) ? DONE : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            count     <= '0;
            err_range <= 1'b0;
        end else begin
            state <= state_nxt;
            if (restart) begin
                mem_addr  <= base_addr;
                count     <= '0;
                err_range <= 1'b0;
            end else begin
                if (drain_out) begin
                    mem_addr <= mem_addr + 64'(ADDR_STEP);
                    count    <= count + 7'd1;
                    mem_we   <= 1'b0;
                end
                if (accept && in_range) begin
                    mem_we    <= 1'b1;
                    mem_wdata <= enc;
                end
                if (accept && !in_range) err_range <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed and randomized checks of the instruction encoder/loader
// against an arithmetic encoding model and an expected write list.
module tb_instr_encoder_loader;
    localparam int DEPTH = 4;
    logic clk = 0, rst_n = 0, start = 0, finish = 0, in_valid = 0, mem_ready = 0;
    logic [63:0] base_addr = 0, in_imm = 0;
    logic [1:0] in_op = 0;
    logic [4:0] in_rt = 0, in_rn = 0;
    logic in_ready, mem_we, busy, done, err_range;
    logic [63:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [6:0] count;
    int checks = 0, failures = 0;
    bit rand_rdy = 0;
    logic [95:0] got_q[$], exp_q[$];
    logic [63:0] m_addr;
    int m_count;
    bit m_err;

    always #5 clk = ~clk;

    instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_STEP(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rt(in_rt), .in_rn(in_rn),
        .in_imm(in_imm), .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .count(count), .busy(busy), .done(done), .err_range(err_range)
    );

    always @(negedge clk) if (rst_n && mem_we && mem_ready) got_q.push_back({mem_addr, mem_wdata});

    function automatic int width_of(input logic [1:0] op);
        return op < 2 ? 9 : (op == 2 ? 19 : 26);
    endfunction

    function automatic bit fits(input logic [1:0] op, input longint imm);
        longint lim = longint'(1) << (width_of(op) - 1);
        return imm >= -lim && imm < lim;
    endfunction

    function automatic logic [31:0] model_enc(input logic [1:0] op, input logic [4:0] rt,
                                              input logic [4:0] rn, input longint imm);
        longint f = imm & ((longint'(1) << width_of(op)) - 1);
        longint r;
        case (op)
            2'd0: r = 64'hF8400000 + f * 4096 + longint'(rn) * 32 + longint'(rt);
            2'd1: r = 64'hF8000000 + f * 4096 + longint'(rn) * 32 + longint'(rt);
            2'd2: r = 64'hB4000000 + f * 32 + longint'(rt);
            default: r = 64'h14000000 + f;
        endcase
        return r[31:0];
    endfunction

    function automatic longint rand_imm(input logic [1:0] op);
        longint lim = longint'(1) << (width_of(op) - 1);
        case ($urandom % 6)
            0: return lim - 1;
            1: return -lim;
            2: return lim;
            3: return -lim - 1;
            4: return longint'($urandom) % (2 * lim) - lim;
            default: return longint'({$urandom, $urandom});
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) mem_ready = 1'($urandom % 2);
        finish = 0;
    endtask

    task automatic do_start(input logic [63:0] b);
        start = 1;
        base_addr = b;
        tick();
        start = 0;
        m_addr = b;
        m_count = 0;
        m_err = 0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic send(input logic [1:0] op, input logic [4:0] rt, input logic [4:0] rn,
                        input longint imm, input bit fin);
        in_valid = 1; in_op = op; in_rt = rt; in_rn = rn; in_imm = imm; finish = fin;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready) begin
                if (fits(op, imm)) begin
                    exp_q.push_back({m_addr, model_enc(op, rt, rn, imm)});
                    m_addr += 4;
                    m_count++;
                end else m_err = 1;
                tick();
                return;
            end
            tick();
        end
        checks++; failures++;
        $display("FAIL send_timeout: in_ready stayed 0, required 1 within 60 cycles");
    endtask

    task automatic idle();
        in_valid = 0;
        finish = 0;
    endtask

    task automatic wait_done(input int bound);
        checks++;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) return;
            tick();
        end
        failures++;
        $display("FAIL wait_done: done=%0b after %0d cycles, required 1", done, bound);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({mem_we, mem_addr, mem_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_mem: we=%0b addr=%h data=%h, required all 0", mem_we, mem_addr, mem_wdata);
        end
        checks++;
        if ({count, err_range} !== '0) begin
            failures++;
            $display("FAIL reset_count: count=%0d err=%0b, required 0 0", count, err_range);
        end
        checks++;
        if ({done, busy, in_ready} !== 3'b000) begin
            failures++;
            $display("FAIL reset_status: done=%0b busy=%0b ready=%0b, required 0 0 0", done, busy, in_ready);
        end
        @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_basic();
        logic [31:0] gold [4] = '{32'hF84402C9, 32'hF80602CB, 32'hB4FFFF6B, 32'h17FFFFC9};
        mem_ready = 1;
        do_start(64'h0);
        send(2'd0, 5'd9, 5'd22, 64, 0);
        send(2'd1, 5'd11, 5'd22, 96, 0);
        send(2'd2, 5'd11, 5'd0, -5, 0);
        send(2'd3, 5'd0, 5'd0, -55, 0);
        idle();
        wait_done(20);
        checks++;
        if (count !== 7'd4) begin
            failures++;
            $display("FAIL basic_count: count=%0d, required 4", count);
        end
        checks++;
        if (got_q.size() != 4) begin
            failures++;
            $display("FAIL basic_writes: %0d writes, required 4", got_q.size());
        end else for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_q[i] !== {64'(4 * i), gold[i]}) begin
                failures++;
                $display("FAIL basic_word%0d: got %h, required %h", i, got_q[i], {64'(4 * i), gold[i]});
            end
        end
    endtask

    task automatic test_range();
        logic [4:0] rt, rn;
        mem_ready = 1;
        do_start(64'h100);
        send(2'd0, 5'd3, 5'd4, 256, 0);
        @(negedge clk);
        checks++;
        if ({mem_we, err_range, count} !== {2'b01, 7'd0}) begin
            failures++;
            $display("FAIL range_drop: we=%0b err=%0b count=%0d, required 0 1 0", mem_we, err_range, count);
        end
        tick();
        rt = 5'($urandom); rn = 5'($urandom);
        send(2'd0, rt, rn, -256, 0);
        idle();
        tick(); tick();
        @(negedge clk);
        checks++;
        if (count !== 7'd1 || err_range !== 1'b1) begin
            failures++;
            $display("FAIL range_count: count=%0d err=%0b, required 1 1", count, err_range);
        end
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {64'h100, 32'hF8500000 | {22'd0, rn, rt}}) begin
            failures++;
            $display("FAIL range_write: n=%0d first=%h, required 1 %h", got_q.size(),
                     got_q.size() ? got_q[0] : 96'd0, {64'h100, 32'hF8500000 | {22'd0, rn, rt}});
        end
        finish = 1;
        tick();
        wait_done(10);
    endtask

    task automatic test_stall();
        mem_ready = 1;
        do_start(64'h2000);
        send(2'd1, 5'd1, 5'd2, 8, 0);
        mem_ready = 0;
        in_op = 2'd0; in_rt = 5'd5; in_rn = 5'd6; in_imm = -8;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (mem_we !== 1'b1 || {mem_addr, mem_wdata} !== exp_q[0] || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold%0d: we=%0b word=%h ready=%0b, required 1 %h 0",
                         i, mem_we, {mem_addr, mem_wdata}, in_ready, exp_q[0]);
            end
            tick();
        end
        mem_ready = 1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_release: in_ready=%0b, required 1", in_ready);
        end
        exp_q.push_back({m_addr, model_enc(2'd0, 5'd5, 5'd6, -8)});
        m_addr += 4;
        m_count++;
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1 || {mem_addr, mem_wdata} !== exp_q[1]) begin
            failures++;
            $display("FAIL stall_issue: we=%0b word=%h, required 1 %h", mem_we, {mem_addr, mem_wdata}, exp_q[1]);
        end
        finish = 1;
        tick();
        wait_done(10);
        checks++;
        if (got_q != exp_q) begin
            failures++;
            $display("FAIL stall_writes: got %0d writes, required %0d matching", got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_depth();
        mem_ready = 1;
        do_start(64'h40);
        for (int i = 0; i < 4; i++) send(2'($urandom), 5'($urandom), 5'($urandom), longint'($urandom % 200) - 100, 0);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL depth_ready: in_ready=%0b after 4th accept, required 0", in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            in_imm = longint'(i);
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL depth_extra%0d: in_ready=%0b, required 0", i, in_ready);
            end
        end
        idle();
        tick();
        wait_done(10);
        checks++;
        if (count !== 7'd4 || got_q != exp_q) begin
            failures++;
            $display("FAIL depth_final: count=%0d writes=%0d, required 4 4 matching", count, got_q.size());
        end
    endtask

    task automatic test_finish();
        logic [4:0] rt;
        mem_ready = 1;
        do_start(64'h300);
        send(2'd2, 5'd7, 5'd0, 262144, 0);
        rt = 5'($urandom);
        send(2'd2, rt, 5'd0, 262143, 1);
        idle();
        wait_done(10);
        checks++;
        if (count !== 7'd1 || err_range !== 1'b1) begin
            failures++;
            $display("FAIL finish_state: count=%0d err=%0b, required 1 1", count, err_range);
        end
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {64'h300, 32'hB47FFFE0 | {27'd0, rt}}) begin
            failures++;
            $display("FAIL finish_word: n=%0d, required 1 write of %h", got_q.size(), 32'hB47FFFE0 | {27'd0, rt});
        end
        do_start(64'h0);
        @(negedge clk);
        checks++;
        if ({count, err_range, done, busy} !== {7'd0, 3'b001}) begin
            failures++;
            $display("FAIL finish_restart: count=%0d err=%0b done=%0b busy=%0b, required 0 0 0 1",
                     count, err_range, done, busy);
        end
        finish = 1;
        tick();
        wait_done(10);
    endtask

    task automatic test_random();
        logic [1:0] op;
        rand_rdy = 1;
        for (int s = 0; s < 8; s++) begin
            do_start({$urandom, $urandom});
            for (int k = 0; k < int'($urandom_range(4, 1)); k++) begin
                op = 2'($urandom);
                send(op, 5'($urandom), 5'($urandom), rand_imm(op), 0);
            end
            idle();
            finish = 1;
            tick();
            wait_done(100);
            checks++;
            if (count !== 7'(m_count) || err_range !== m_err) begin
                failures++;
                $display("FAIL rand%0d_state: count=%0d err=%0b, required %0d %0b", s, count, err_range, m_count, m_err);
            end
            checks++;
            if (got_q != exp_q) begin
                failures++;
                $display("FAIL rand%0d_writes: got %0d writes, required %0d matching", s, got_q.size(), exp_q.size());
            end
        end
        rand_rdy = 0;
        mem_ready = 1;
    endtask

    task automatic test_reset_mid();
        mem_ready = 1;
        do_start(64'h500);
        send(2'd0, 5'd1, 5'd1, 16, 0);
        send(2'd1, 5'd2, 5'd3, 24, 0);
        mem_ready = 0;
        idle();
        @(negedge clk);
        checks++;
        if (count !== 7'd1 || mem_we !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre: count=%0d we=%0b, required 1 1", count, mem_we);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if ({mem_we, count, in_ready, busy, done} !== '0) begin
            failures++;
            $display("FAIL midrst_clear: we=%0b count=%0d ready=%0b busy=%0b done=%0b, required all 0",
                     mem_we, count, in_ready, busy, done);
        end
        @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        checks++;
        if ({mem_we, busy, done, in_ready} !== 4'b0000) begin
            failures++;
            $display("FAIL midrst_idle: we=%0b busy=%0b done=%0b ready=%0b, required 0 0 0 0",
                     mem_we, busy, done, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_range();
        test_stall();
        test_depth();
        test_finish();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
